// File: rtl/uart_rx_controller.sv
`timescale 1ns/1ps
// UART receive control FSM: sequences the RX datapath through start, data,
// optional parity and one or two stop bits, pushes good bytes and flags errors.
module uart_rx_controller #(
  parameter bit FALSE_START_CHECK = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic baud16_tick,
  input  logic parity_en,
  input  logic stop_bits_two,
  input  logic error_clear,
  input  logic rx_sync,
  input  logic rx_sync_fall,
  input  logic rx_get_sample,
  input  logic rx_sample_cnt_top,
  input  logic rx_bits_cnt_top,
  input  logic rx_parity_out,
  input  logic rx_queue_full,
  output logic rx_sync_en,
  output logic rx_sample_reg_we,
  output logic rx_sample_reg_reset,
  output logic rx_queue_we,
  output logic rx_parity_we,
  output logic rx_parity_reset,
  output logic rx_bits_cnt_en,
  output logic rx_bits_cnt_reset,
  output logic rx_sample_cnt_en,
  output logic rx_sample_cnt_reset,
  output logic rx_error_reg_set,
  output logic rx_error_reg_reset,
  output logic busy,
  output logic frame_err,
  output logic parity_err,
  output logic overrun_err
);

  typedef enum logic [3:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP_END,
    STOP2,
    PUSH,
    BREAK
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   par_ok;
  logic   s_tick;
  logic   e_tick;
  logic   par_ok_eff;
  logic   hold_cnt_reset;

  assign s_tick     = baud16_tick & rx_get_sample;
  assign e_tick     = baud16_tick & rx_sample_cnt_top;
  assign par_ok_eff = par_ok | ~parity_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      par_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        par_ok <= 1'b0;
      else if ((state == PARITY) && s_tick)
        par_ok <= (rx_sync == rx_parity_out);
    end
  end

  always_comb begin
    state_nxt        = state;
    hold_cnt_reset   = 1'b0;
    rx_sample_reg_we = 1'b0;
    rx_queue_we      = 1'b0;
    rx_parity_we     = 1'b0;
    rx_bits_cnt_en   = 1'b0;
    rx_error_reg_set = 1'b0;
    frame_err        = 1'b0;
    parity_err       = 1'b0;
    overrun_err      = 1'b0;
    rx_sample_cnt_en = baud16_tick & (state != IDLE) & (state != PUSH);
    busy             = (state != IDLE);

    case (state)
      IDLE: begin
        // Counters come out of reset on the edge itself so START counts from 0.
        hold_cnt_reset = ~rx_sync_fall;
        if (rx_sync_fall)
          state_nxt = START;
      end
      START: begin
        if (s_tick && rx_sync && FALSE_START_CHECK)
          state_nxt = IDLE;
        else if (e_tick)
          state_nxt = DATA;
      end
      DATA: begin
        if (s_tick) begin
          rx_sample_reg_we = 1'b1;
          rx_parity_we     = 1'b1;
          rx_bits_cnt_en   = 1'b1;
        end
        if (e_tick && rx_bits_cnt_top)
          state_nxt = parity_en ? PARITY : STOP;
      end
      PARITY: begin
        if (e_tick)
          state_nxt = STOP;
      end
      STOP: begin
        // Leaving at mid-stop leaves half a bit to resync onto the next start edge.
        if (s_tick) begin
          if (!rx_sync) begin
            frame_err        = 1'b1;
            rx_error_reg_set = 1'b1;
            state_nxt        = BREAK;
          end else if (!par_ok_eff) begin
            parity_err       = 1'b1;
            rx_error_reg_set = 1'b1;
            state_nxt        = IDLE;
          end else if (stop_bits_two) begin
            state_nxt = STOP_END;
          end else begin
            state_nxt = PUSH;
          end
        end
      end
      STOP_END: begin
        if (e_tick)
          state_nxt = STOP2;
      end
      STOP2: begin
        if (s_tick) begin
          if (!rx_sync) begin
            frame_err        = 1'b1;
            rx_error_reg_set = 1'b1;
            state_nxt        = BREAK;
          end else begin
            state_nxt = PUSH;
          end
        end
      end
      PUSH: begin
        if (rx_queue_full) begin
          overrun_err      = 1'b1;
          rx_error_reg_set = 1'b1;
        end else begin
          rx_queue_we = 1'b1;
        end
        state_nxt = IDLE;
      end
      BREAK: begin
        if (rx_sync)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset overrides everything so a partial frame can never write or flag.
    if (reset) begin
      hold_cnt_reset   = 1'b1;
      rx_sample_reg_we = 1'b0;
      rx_queue_we      = 1'b0;
      rx_parity_we     = 1'b0;
      rx_bits_cnt_en   = 1'b0;
      rx_sample_cnt_en = 1'b0;
      rx_error_reg_set = 1'b0;
      frame_err        = 1'b0;
      parity_err       = 1'b0;
      overrun_err      = 1'b0;
      busy             = 1'b0;
    end
  end

  assign rx_sync_en          = ~reset;
  assign rx_error_reg_reset  = reset | error_clear;
  assign rx_sample_reg_reset = hold_cnt_reset;
  assign rx_parity_reset     = hold_cnt_reset;
  assign rx_bits_cnt_reset   = hold_cnt_reset;
  assign rx_sample_cnt_reset = hold_cnt_reset;

endmodule

// File: tb/tb_uart_rx_controller.sv
`timescale 1ns/1ps
// Bench for uart_rx_controller: behavioural RX datapath around two instances
// (false-start check on/off), serial line driver, byte scoreboard.
module tb_uart_rx_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tick_en, tick_gen, tick_force, baud16_tick;
  logic parity_en, stop_bits_two, error_clear, rx_sync, rx_queue_full;
  logic sync_d, fall_force, rx_sync_fall;
  logic [1:0] div;
  int   tick_count;

  assign baud16_tick  = tick_gen | tick_force;
  assign rx_sync_fall = (sync_d & ~rx_sync) | fall_force;

  logic get_sample [2], sc_top [2], bits_top [2], par_out [2];
  logic sync_en [2], sreg_we [2], sreg_rst [2], q_we [2], par_we [2], par_rst [2];
  logic bits_en [2], bits_rst [2], sc_en [2], sc_rst [2], err_set [2], err_rst [2];
  logic busy [2], frame_err [2], parity_err [2], overrun_err [2];

  logic [3:0] sc   [2];
  logic [3:0] bc   [2];
  logic [7:0] dat  [2];
  logic       par  [2];
  logic       err_reg [2];

  uart_rx_controller u0 (
    .clk(clk), .reset(reset), .baud16_tick(baud16_tick), .parity_en(parity_en),
    .stop_bits_two(stop_bits_two), .error_clear(error_clear), .rx_sync(rx_sync),
    .rx_sync_fall(rx_sync_fall), .rx_get_sample(get_sample[0]), .rx_sample_cnt_top(sc_top[0]),
    .rx_bits_cnt_top(bits_top[0]), .rx_parity_out(par_out[0]), .rx_queue_full(rx_queue_full),
    .rx_sync_en(sync_en[0]), .rx_sample_reg_we(sreg_we[0]), .rx_sample_reg_reset(sreg_rst[0]),
    .rx_queue_we(q_we[0]), .rx_parity_we(par_we[0]), .rx_parity_reset(par_rst[0]),
    .rx_bits_cnt_en(bits_en[0]), .rx_bits_cnt_reset(bits_rst[0]), .rx_sample_cnt_en(sc_en[0]),
    .rx_sample_cnt_reset(sc_rst[0]), .rx_error_reg_set(err_set[0]), .rx_error_reg_reset(err_rst[0]),
    .busy(busy[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun_err(overrun_err[0])
  );

  uart_rx_controller #(.FALSE_START_CHECK(1'b0)) u1 (
    .clk(clk), .reset(reset), .baud16_tick(baud16_tick), .parity_en(parity_en),
    .stop_bits_two(stop_bits_two), .error_clear(error_clear), .rx_sync(rx_sync),
    .rx_sync_fall(rx_sync_fall), .rx_get_sample(get_sample[1]), .rx_sample_cnt_top(sc_top[1]),
    .rx_bits_cnt_top(bits_top[1]), .rx_parity_out(par_out[1]), .rx_queue_full(rx_queue_full),
    .rx_sync_en(sync_en[1]), .rx_sample_reg_we(sreg_we[1]), .rx_sample_reg_reset(sreg_rst[1]),
    .rx_queue_we(q_we[1]), .rx_parity_we(par_we[1]), .rx_parity_reset(par_rst[1]),
    .rx_bits_cnt_en(bits_en[1]), .rx_bits_cnt_reset(bits_rst[1]), .rx_sample_cnt_en(sc_en[1]),
    .rx_sample_cnt_reset(sc_rst[1]), .rx_error_reg_set(err_set[1]), .rx_error_reg_reset(err_rst[1]),
    .busy(busy[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun_err(overrun_err[1])
  );

  // Tick generator: one pulse every 4 clk while enabled.
  always @(posedge clk) begin
    if (!tick_en) begin
      div      <= 2'd0;
      tick_gen <= 1'b0;
    end else begin
      div      <= div + 2'd1;
      tick_gen <= (div == 2'd3);
    end
    if (baud16_tick) tick_count <= tick_count + 1;
    sync_d <= rx_sync;
  end

  // Behavioural RX datapath (counters, shift register, even parity, sticky error).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sc_rst[i]) sc[i] <= 4'd0;
      else if (sc_en[i]) sc[i] <= sc[i] + 4'd1;
      if (bits_rst[i]) bc[i] <= 4'd0;
      else if (bits_en[i]) bc[i] <= bc[i] + 4'd1;
      if (sreg_rst[i]) dat[i] <= 8'd0;
      else if (sreg_we[i]) dat[i] <= {rx_sync, dat[i][7:1]};
      if (par_rst[i]) par[i] <= 1'b0;
      else if (par_we[i]) par[i] <= par[i] ^ rx_sync;
      if (err_rst[i]) err_reg[i] <= 1'b0;
      else if (err_set[i]) err_reg[i] <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      get_sample[i] = (sc[i] == 4'd7);
      sc_top[i]     = (sc[i] == 4'd15);
      bits_top[i]   = (bc[i] == 4'd8);
      par_out[i]    = par[i];
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  // Scoreboard and event monitor.
  logic [7:0] exp_q [$];
  logic [7:0] last1;
  int push_cnt = 0, push1_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  logic push_prev = 1'b0;

  always @(negedge clk) begin
    if (push_prev) check("busy_after_push", int'(busy[0]), 0);
    push_prev <= q_we[0];
    if (q_we[0]) begin
      push_cnt <= push_cnt + 1;
      if (exp_q.size() == 0) check("unexpected_push", int'(dat[0]), -1);
      else check("push_data", int'(dat[0]), int'(exp_q.pop_front()));
    end
    if (q_we[1]) begin
      push1_cnt <= push1_cnt + 1;
      last1     <= dat[1];
    end
    if (frame_err[0])   fe_cnt <= fe_cnt + 1;
    if (parity_err[0])  pe_cnt <= pe_cnt + 1;
    if (overrun_err[0]) ov_cnt <= ov_cnt + 1;
  end

  typedef struct {
    logic       rst;
    logic       tick;
    logic       clr;
    logic       fall;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_count + n;
    guard  = 0;
    while (tick_count < target && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout actual=%0d required=%0d", tick_count, target);
    end
  endtask

  task automatic send_bit(input logic v);
    rx_sync = v;
    wait_ticks(16);
  endtask

  // pmode: 0 = no parity bit, 1 = correct even parity, 2 = wrong parity.
  task automatic send_frame(input logic [7:0] b, input int pmode, input logic stop_v, input bit push);
    if (push) exp_q.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (pmode == 1) send_bit(^b);
    else if (pmode == 2) send_bit(~^b);
    send_bit(stop_v);
    if (stop_bits_two) send_bit(stop_v);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 error_clear = 1'b1;
    @(posedge clk); #1 error_clear = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, fe0, pe0, ov0, p10;
    reset = 1'b1; tick_en = 1'b0; tick_force = 1'b0; fall_force = 1'b0;
    parity_en = 1'b0; stop_bits_two = 1'b0; error_clear = 1'b0;
    rx_sync = 1'b1; rx_queue_full = 1'b0; tick_count = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // {rst,tick,clr,fall} -> {sync_en,err_rst,sc_rst,bits_rst,sc_en,busy,q_we} in IDLE
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0111000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1011000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b1111000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b1011000};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0111000};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b1100000};
    for (int v = 0; v < 7; v++) begin
      @(negedge clk); #1;
      reset = vecs[v].rst; tick_force = vecs[v].tick;
      error_clear = vecs[v].clr; fall_force = vecs[v].fall;
      #1;
      check($sformatf("idle_vec%0d", v),
            int'({sync_en[0], err_rst[0], sc_rst[0], bits_rst[0], sc_en[0], busy[0], q_we[0]}),
            int'(vecs[v].exp));
      #1;
      reset = 1'b0; tick_force = 1'b0; error_clear = 1'b0; fall_force = 1'b0;
    end
    tick_en = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5
    p0 = push_cnt; fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 0, 1'b1, 1'b1);
    wait_ticks(4);
    check("a5_push_count", push_cnt - p0, 1);
    check("a5_errors", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    check("a5_queue_drained", exp_q.size(), 0);

    // 8E1 0x07, good then bad parity
    parity_en = 1'b1;
    p0 = push_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1, 1'b1, 1'b1);
    wait_ticks(4);
    check("par_good_push", push_cnt - p0, 1);
    check("par_good_no_err", pe_cnt - pe0, 0);
    send_frame(8'h07, 2, 1'b1, 1'b0);
    wait_ticks(4);
    check("par_bad_pulse", pe_cnt - pe0, 1);
    check("par_bad_no_push", push_cnt - p0, 1);
    check("par_bad_sticky", int'(err_reg[0]), 1);
    pulse_clear();
    check("par_clear", int'(err_reg[0]), 0);
    parity_en = 1'b0;

    // Stop bit low, line held low 3 bit times, then 0x3C
    p0 = push_cnt; fe0 = fe_cnt;
    send_frame(8'h81, 0, 1'b0, 1'b0);
    check("brk_frame_err", fe_cnt - fe0, 1);
    check("brk_busy_low", int'(busy[0]), 1);
    wait_ticks(32);
    check("brk_busy_still", int'(busy[0]), 1);
    rx_sync = 1'b1;
    wait_ticks(2);
    check("brk_idle_after_rise", int'(busy[0]), 0);
    check("brk_no_push", push_cnt - p0, 0);
    send_frame(8'h3C, 0, 1'b1, 1'b1);
    wait_ticks(4);
    check("brk_3c_push", push_cnt - p0, 1);
    check("brk_queue_drained", exp_q.size(), 0);
    pulse_clear();

    // Glitch: 4 ticks low
    p0 = push_cnt; p10 = push1_cnt; fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    rx_sync = 1'b0;
    wait_ticks(4);
    rx_sync = 1'b1;
    wait_ticks(16);
    check("glitch_idle", int'(busy[0]), 0);
    check("glitch_nochk_busy", int'(busy[1]), 1);
    wait_ticks(160);
    check("glitch_no_push", push_cnt - p0, 0);
    check("glitch_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    check("glitch_nochk_push", push1_cnt - p10, 1);
    check("glitch_nochk_data", int'(last1), 8'hFF);

    // FIFO full, 0x55
    rx_queue_full = 1'b1;
    p0 = push_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 0, 1'b1, 1'b0);
    wait_ticks(4);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_no_push", push_cnt - p0, 0);
    check("ovr_sticky", int'(err_reg[0]), 1);
    rx_queue_full = 1'b0;
    pulse_clear();

    // No ticks: FSM holds in START
    tick_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_sync = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("noticks_hold", int'(busy[0]), 1);
    rx_sync = 1'b1;
    pulse_reset();
    check("noticks_reset_idle", int'(busy[0]), 0);
    tick_en = 1'b1;
    wait_ticks(4);

    // 8N2 back-to-back, then reset in the middle of a third byte
    stop_bits_two = 1'b1;
    p0 = push_cnt;
    send_frame(8'h01, 0, 1'b1, 1'b1);
    send_frame(8'hFE, 0, 1'b1, 1'b1);
    wait_ticks(4);
    check("n2_push_count", push_cnt - p0, 2);
    check("n2_queue_drained", exp_q.size(), 0);
    send_bit(1'b0);
    rx_sync = 1'b1;
    wait_ticks(40);
    check("n2_third_busy", int'(busy[0]), 1);
    pulse_reset();
    check("n2_reset_idle", int'(busy[0]), 0);
    check("n2_reset_counters",
          int'({sc_rst[0], bits_rst[0], sreg_rst[0], par_rst[0]}), 4'b1111);
    wait_ticks(200);
    check("n2_third_not_pushed", push_cnt - p0, 2);
    check("n2_still_idle", int'(busy[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
